// File: rtl/d_latch.sv
//------------------------------------------------------------------------------
// Module      : d_latch
// Description : WIDTH-bit level-sensitive D latch with asynchronous clear and
//               complementary outputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module d_latch #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    input  logic             Reset,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    logic [WIDTH-1:0] r_q;

    // Clear has priority over transparency so the latch stays at zero for as
    // long as Reset is held, whatever En and D do.
    always_latch begin
        if (Reset) begin
            r_q <= '0;
        end else if (En) begin
            r_q <= D;
        end
    end

    assign Q    = r_q;
    assign Qbar = ~r_q;

endmodule

`default_nettype wire

// File: rtl/d_flip_flop.sv
//------------------------------------------------------------------------------
// Module      : d_flip_flop
// Description : Rising-edge WIDTH-bit D flip-flop with asynchronous active-high
//               clear, built from a master/slave pair of d_latch instances.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module d_flip_flop #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    logic             w_master_en;
    logic [WIDTH-1:0] w_master_q;
    logic [WIDTH-1:0] w_unused_master_qbar;

    // Master follows D while Clk is low; the slave copies the master while
    // Clk is high, so Q only moves on the rising edge.
    assign w_master_en = ~Clk;

    d_latch #(
        .WIDTH (WIDTH)
    ) u_master (
        .D     (D),
        .En    (w_master_en),
        .Reset (Reset),
        .Q     (w_master_q),
        .Qbar  (w_unused_master_qbar)
    );

    d_latch #(
        .WIDTH (WIDTH)
    ) u_slave (
        .D     (w_master_q),
        .En    (Clk),
        .Reset (Reset),
        .Q     (Q),
        .Qbar  (Qbar)
    );

endmodule

`default_nettype wire

// File: tb/tb_d_flip_flop.sv
//------------------------------------------------------------------------------
// Module      : tb_d_flip_flop
// Description : Self-checking bench for d_flip_flop at WIDTH=1 and WIDTH=4.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_d_flip_flop;

    logic       Clk;
    logic       Reset;
    logic [0:0] D1;
    logic [0:0] Q1;
    logic [0:0] Qbar1;
    logic [3:0] D4;
    logic [3:0] Q4;
    logic [3:0] Qbar4;

    // Reference: the value each register is supposed to hold right now.
    logic [0:0] exp1;
    logic [3:0] exp4;

    int checks   = 0;
    int failures = 0;

    d_flip_flop #(.WIDTH(1)) dut1 (
        .Clk   (Clk),
        .Reset (Reset),
        .D     (D1),
        .Q     (Q1),
        .Qbar  (Qbar1)
    );

    d_flip_flop #(.WIDTH(4)) dut4 (
        .Clk   (Clk),
        .Reset (Reset),
        .D     (D4),
        .Q     (Q4),
        .Qbar  (Qbar4)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Qbar expectation is derived from the model value, never from Q.
    task automatic check_all(input string tag);
        chk({tag, "_q1"},    {3'b000, Q1},    {3'b000, exp1});
        chk({tag, "_qbar1"}, {3'b000, Qbar1}, {3'b000, ~exp1});
        chk({tag, "_q4"},    Q4,              exp4);
        chk({tag, "_qbar4"}, Qbar4,           ~exp4);
    endtask

    // Present data while Clk is low, take one rising edge, update the model,
    // check; optionally disturb D while Clk is high and check Q held.
    task automatic cycle(input string tag, input logic d1, input logic [3:0] d4, input bit glitch);
        @(negedge Clk);
        D1 = d1;
        D4 = d4;
        @(posedge Clk);
        #1;
        if (Reset) begin
            exp1 = 1'b0;
            exp4 = 4'b0000;
        end else begin
            exp1 = d1;
            exp4 = d4;
        end
        check_all(tag);
        if (glitch) begin
            #3;
            D1 = ~d1;
            D4 = ~d4;
            #3;
            check_all({tag, "_hold_high"});
        end
    endtask

    initial begin
        Reset = 1'b1;
        D1    = 1'b0;
        D4    = 4'b0000;
        exp1  = 1'b0;
        exp4  = 4'b0000;

        // Power-up reset across five rising edges (10..90 ns).
        #1;
        check_all("por_t1");
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            check_all("por_edge");
        end

        // Release at 100 ns: no output change.
        #9;
        Reset = 1'b0;
        #1;
        check_all("release");

        // From 120 ns D toggles every 40 ns; two rising edges per D value.
        #19;
        for (int i = 0; i < 6; i++) begin
            D1 = ~D1;
            D4 = ~D4;
            @(posedge Clk);
            #1;
            exp1 = D1;
            exp4 = D4;
            check_all("toggle_e1");
            @(posedge Clk);
            #1;
            check_all("toggle_e2");
            #9;
        end

        // D pulses high while Clk is high, and again while Clk is low, both
        // returning to 0 before the next edge.
        cycle("zero", 1'b0, 4'b0000, 1'b0);
        #2;
        D1 = 1'b1;
        D4 = 4'b1111;
        #2;
        check_all("pulse_high");
        @(negedge Clk);
        #2;
        check_all("pulse_high_fall");
        D1 = 1'b0;
        D4 = 4'b0000;
        #2;
        D1 = 1'b1;
        D4 = 4'b1111;
        #2;
        D1 = 1'b0;
        D4 = 4'b0000;
        check_all("pulse_low");
        @(posedge Clk);
        #1;
        check_all("pulse_capture0");

        // Asynchronous reset 5 ns after a rising edge, Clk still high.
        cycle("set1", 1'b1, 4'b1010, 1'b0);
        #4;
        Reset = 1'b1;
        exp1  = 1'b0;
        exp4  = 4'b0000;
        #1;
        check_all("async_rst");
        D1 = 1'b1;
        D4 = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            #1;
            check_all("rst_hold");
        end

        // Release coincident with a rising edge; the NBA lets the edge settle
        // in the same timestep before Reset falls, so that edge is ignored.
        @(posedge Clk);
        Reset <= 1'b0;
        #1;
        check_all("coincident_edge");
        @(posedge Clk);
        #1;
        exp1 = 1'b1;
        exp4 = 4'b1111;
        check_all("coincident_next");

        // Wide-bank pattern and its reset.
        cycle("w4_1010", 1'b0, 4'b1010, 1'b0);
        #3;
        Reset = 1'b1;
        exp1  = 1'b0;
        exp4  = 4'b0000;
        #1;
        check_all("w4_reset");
        @(negedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        check_all("w4_release");

        // Random data with random disturbances between edges.
        for (int i = 0; i < 40; i++) begin
            cycle("rand", 1'($urandom), 4'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
